// File: rtl/uart_pkg.sv
// Shared UART types and default timing constants.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned BIT_IDX_W    = 3;

    // Transmitter frame phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // Integer clocks per line bit.
    function automatic int unsigned clks_per_bit(int unsigned clk_freq, int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Requester-to-transmitter handshake plus the serial line.
interface uart_tx_if;
    import uart_pkg::*;

    logic              start;
    logic [DATA_W-1:0] data;
    logic              tx;
    logic              busy;

    modport master (output start, output data, input tx, input busy);
    modport slave  (input start, input data, output tx, output busy);

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one accepted start sends one frame, tx/busy straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    // A bit period shorter than two clocks cannot be timed by this counter.
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    state_e               state_q;
    logic [CNT_W-1:0]     baud_cnt_q;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic [DATA_W-1:0]    shift_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 bit_end_c;

    // Last clock of the current bit period.
    assign bit_end_c = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Frame sequencer; the shift register always presents the next data bit in bit 0/1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shift_q    <= bus.data;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == BIT_IDX_W'(DATA_W - 1)) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q      <= shift_q[1];
                            shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
                            bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        baud_cnt_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    baud_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    tx_q       <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: default-rate directed frames plus a fast-rate random run.
module tb_uart_tx;

    localparam int CPB  = 434;   // 50 MHz / 115200
    localparam int FCPB = 10;    // 1 MHz / 100 kHz

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_tx_if if_def ();
    uart_tx_if if_fast ();

    uart_tx #(.CLK_FREQ(50_000_000), .BAUD(115_200)) dut_def (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_def)
    );

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fast)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         collide_at;   // cycle into the frame for an ignored start, -1 for none
        logic [9:0] exp_bits;     // expected line levels, index 0 = first bit on the wire
    } vec_t;

    vec_t tbl [4];

    // receiver model state
    bit         rx_en = 1'b0;
    logic       rx_prev;
    logic [7:0] rx_q [$];
    int         rx_ferr = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Send one byte on the default DUT and check every bit level, busy length, and return to idle.
    task automatic run_frame(input logic [7:0] d, input int collide_at,
                             input logic [9:0] exp_bits, input string tag);
        int mism [10];
        int busy_bad;
        int k;
        for (int i = 0; i < 10; i++) mism[i] = 0;
        busy_bad = 0;
        if_def.data  = d;
        if_def.start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            k = c / CPB;
            if (if_def.tx !== exp_bits[k]) mism[k]++;
            if (if_def.busy !== 1'b1) busy_bad++;
            if (c == collide_at) begin
                if_def.start = 1'b1;
                if_def.data  = 8'hFF;
            end else begin
                if_def.start = 1'b0;
                if_def.data  = 8'($urandom);
            end
        end
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("%s bit%0d mismatched cycles (level %0b)", tag, i, exp_bits[i]),
                     mism[i], 0);
        check_eq($sformatf("%s busy low cycles in frame", tag), busy_bad, 0);
        @(negedge clk);
        check_eq($sformatf("%s busy after frame", tag), int'(if_def.busy), 0);
        check_eq($sformatf("%s tx after frame", tag), int'(if_def.tx), 1);
    endtask

    // Mid-bit sampling receiver on the default line.
    initial begin
        logic [7:0] b;
        rx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_en && rx_prev === 1'b1 && if_def.tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (if_def.tx !== 1'b0) rx_ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = if_def.tx;
                end
                repeat (CPB) @(negedge clk);
                if (if_def.tx !== 1'b1) rx_ferr++;
                rx_q.push_back(b);
                rx_prev = 1'b1;
            end else begin
                rx_prev = if_def.tx;
            end
        end
    end

    initial begin
        int tx_bad, busy_bad, cnt;
        int rem, el, exp_tx, exp_busy;
        logic [9:0] fb;

        tbl[0] = '{8'h4D, 1000, 10'h29A};
        tbl[1] = '{8'hA5, -1,   10'h34A};
        tbl[2] = '{8'hFF, 2000, 10'h3FE};
        tbl[3] = '{8'h00, 10,   10'h200};

        rst_n = 1'b0;
        if_def.start  = 1'b0;
        if_def.data   = 8'h00;
        if_fast.start = 1'b0;
        if_fast.data  = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        check_eq("reset tx", int'(if_def.tx), 1);
        check_eq("reset busy", int'(if_def.busy), 0);
        check_eq("reset fast tx", int'(if_fast.tx), 1);
        check_eq("reset fast busy", int'(if_fast.busy), 0);
        rst_n = 1'b1;

        // idle for 100 cycles
        tx_bad = 0;
        busy_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (if_def.tx !== 1'b1) tx_bad++;
            if (if_def.busy !== 1'b0) busy_bad++;
        end
        check_eq("idle tx not high cycles", tx_bad, 0);
        check_eq("idle busy high cycles", busy_bad, 0);

        // table-driven frames, some with an ignored start mid-frame
        for (int v = 0; v < 4; v++)
            run_frame(tbl[v].data, tbl[v].collide_at, tbl[v].exp_bits,
                      $sformatf("vec%0d", v));

        // back-to-back frames decoded by the receiver model
        rx_q.delete();
        rx_en = 1'b1;
        run_frame(8'h0D, -1, 10'h21A, "b2b0");
        run_frame(8'h0A, -1, 10'h214, "b2b1");
        repeat (5) @(negedge clk);
        rx_en = 1'b0;
        check_eq("rx byte count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check_eq("rx byte0", int'(rx_q[0]), 8'h0D);
            check_eq("rx byte1", int'(rx_q[1]), 8'h0A);
        end
        check_eq("rx framing errors", rx_ferr, 0);

        // reset during data bit 3 aborts the frame
        if_def.data  = 8'hA5;
        if_def.start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 4 * CPB + 200; c++) begin
            @(negedge clk);
            if_def.start = 1'b0;
        end
        check_eq("pre-abort tx (data bit3 of A5)", int'(if_def.tx), 0);
        check_eq("pre-abort busy", int'(if_def.busy), 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort tx", int'(if_def.tx), 1);
        check_eq("abort busy", int'(if_def.busy), 0);
        repeat (3) @(negedge clk);
        check_eq("held reset busy", int'(if_def.busy), 0);
        rst_n = 1'b1;
        run_frame(8'h00, -1, 10'h200, "post_reset");

        // fast instance: a single frame holds busy for 10 bits of 10 clocks
        if_fast.data  = 8'h5A;
        if_fast.start = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if_fast.start = 1'b0;
            if (if_fast.busy === 1'b1) cnt++;
        end
        check_eq("fast busy length", cnt, 10 * FCPB);

        // fast instance: random starts and data against a frame-level model
        rem = 0;
        el  = 0;
        fb  = '1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_busy = (rem > 0) ? 1 : 0;
            exp_tx   = (rem > 0) ? int'(fb[el / FCPB]) : 1;
            check_eq($sformatf("rand tx cyc%0d", cyc), int'(if_fast.tx), exp_tx);
            check_eq($sformatf("rand busy cyc%0d", cyc), int'(if_fast.busy), exp_busy);
            if_fast.start = ($urandom_range(0, 7) == 0);
            if_fast.data  = 8'($urandom);
            if (rem == 0 && if_fast.start) begin
                fb  = {1'b1, if_fast.data, 1'b0};
                rem = 10 * FCPB;
                el  = 0;
            end else if (rem > 0) begin
                rem--;
                el++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, meaning: clk frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, meaning: line bit rate in bits/s.
REQ-003 Derived constant CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 434 at defaults); elaboration SHALL fail if CLKS_PER_BIT < 2.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to transmit data.
REQ-007 data  input  8  byte to transmit; sampled only when a start is accepted.
REQ-008 tx  output  1  serial line, 8N1, idle high.
REQ-009 busy  output  1  high while a frame is in progress.

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 Each bit SHALL be held on tx for exactly CLKS_PER_BIT clk cycles.
REQ-012 The FSM SHALL have states IDLE, START, DATA and STOP; any unused encoding SHALL return to IDLE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL latch data into a shift register, set busy=1, drive tx=0 and enter START, all on that same edge.
REQ-014 Consequently busy SHALL read 1 in the cycle immediately after the start pulse, so a requester polling "!busy && !start" never sees a false idle.
REQ-015 START -> DATA after CLKS_PER_BIT cycles; tx = data[0].
REQ-016 DATA SHALL shift out bits 0..7 using a 3-bit bit index; after bit 7 has been held for CLKS_PER_BIT cycles -> STOP with tx=1.
REQ-017 STOP -> IDLE after CLKS_PER_BIT cycles; busy cleared on that edge; tx remains 1.
REQ-018 busy SHALL be high for exactly 10*CLKS_PER_BIT cycles per frame (4340 at defaults).
REQ-019 start asserted while busy=1 SHALL be ignored (no queueing); data changes during a frame SHALL not affect the frame.
REQ-020 start in the first cycle with busy=0 SHALL be accepted, giving back-to-back frames with no extra idle time beyond the stop bit.
REQ-021 tx and busy SHALL be driven directly from flip-flops (glitch-free).
REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and be cleared at every bit boundary and on accept.

Reset
REQ-023 On rst_n low, asynchronously: state=IDLE, tx=1, busy=0, baud counter=0, bit index=0, shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (tx returns high); the first start after release SHALL begin a fresh frame.
REQ-025 start sampled in the first edge after rst_n release SHALL be accepted normally.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP) and the default CLK_FREQ/BAUD constants.
REQ-027 No sub-module is required; optionally a baud_tick counter sub-module named uart_baud_cnt.

Verification
REQ-028 Reset then idle 100 cycles -> tx=1, busy=0 throughout.
REQ-029 start pulse with data=8'h4D ("M") at defaults -> busy=1 next cycle; tx sequence 0,1,0,1,1,0,0,1,0,1, each bit 434 cycles; busy=1 for 4340 cycles.
REQ-030 Second start pulse (data=8'hFF) issued 1000 cycles into a frame -> ignored; frame unchanged and busy falls at 4340.
REQ-031 Back-to-back bytes 8'h0D then 8'h0A, with each start issued in the first cycle busy=0 -> contiguous frames; a UART receiver model decodes 0x0D, 0x0A with no framing error.
REQ-032 rst_n pulsed low during DATA bit 3 -> tx=1 and busy=0 immediately; next start with data=8'h00 -> a correct full frame.
REQ-033 Parameter override CLK_FREQ=1_000_000, BAUD=100_000 -> 10 cycles per bit, busy for 100 cycles.
